rx_fir_sequencer: RTL and testbench
===================================

RX_FIR_SEQUENCER -- requirements
Module: rx_fir_sequencer

Interface
REQ-001 Parameter TAPS, default 256: FIR length; power of two, 4..1024.
REQ-002 Parameter DECIMATION, default 2: input strobes per output sample; 1..16.
REQ-003 Parameter RD_LATENCY, default 1: sample-RAM/coeff-ROM read latency in cycles; 1..3.
REQ-004 Constant AW = log2(TAPS): address width.
REQ-005 clock  in  1: 122.88 MHz system clock; all logic on its rising edge.
REQ-006 reset  in  1: asynchronous, active-high.
REQ-007 in_strobe  in  1: one-cycle pulse marking a new CIC output sample on the data bus.
REQ-008 wr_en  out  1: sample-RAM write enable.
REQ-009 wr_addr  out  AW: sample-RAM write address.
REQ-010 rd_addr  out  AW: sample-RAM read address.
REQ-011 coeff_addr  out  AW: coefficient-ROM address.
REQ-012 mac_first  out  1: MAC loads the product instead of accumulating.
REQ-013 mac_en  out  1: MAC accumulate enable.
REQ-014 out_strobe  out  1: one-cycle pulse; MAC result valid.
REQ-015 busy  out  1: convolution in progress.
REQ-016 overrun  out  1: sticky; a start request was dropped.

Function
REQ-017 wr_en SHALL equal in_strobe combinationally, in every state.
REQ-018 wr_addr SHALL increment modulo TAPS on the cycle after each write; wrap TAPS-1 -> 0.
REQ-019 Phase counter SHALL count in_strobe modulo DECIMATION; a start request SHALL be raised by the strobe that takes it from DECIMATION-1 to 0.
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE + start request at cycle T (write at address A) -> RUN at T+1.
REQ-022 RUN SHALL last exactly TAPS cycles; in the k-th cycle (k=0..TAPS-1): rd_addr = (A-k) mod TAPS, coeff_addr = k.
REQ-023 RUN -> DRAIN after k=TAPS-1; DRAIN SHALL last RD_LATENCY cycles; DRAIN -> DONE.
REQ-024 mac_en SHALL be high exactly TAPS cycles, from T+1+RD_LATENCY to T+TAPS+RD_LATENCY.
REQ-025 mac_first SHALL be high only in the first mac_en cycle.
REQ-026 DONE SHALL last one cycle with out_strobe=1 (cycle T+TAPS+RD_LATENCY+1), then -> IDLE.
REQ-027 busy SHALL be high in RUN, DRAIN and DONE.
REQ-028 in_strobe while busy SHALL still write and advance wr_addr and the phase counter.
REQ-029 A start request while busy SHALL be discarded and SHALL set overrun; overrun clears only on reset.
REQ-030 A start request in the DONE cycle SHALL be discarded as overrun (no back-to-back restart).
REQ-031 Outside mac_en cycles, rd_addr and coeff_addr SHALL hold their last value.

Reset
REQ-032 Reset SHALL force IDLE, wr_addr=0, rd_addr=0, coeff_addr=0, phase=0, mac_en=0, mac_first=0, out_strobe=0, busy=0, overrun=0; wr_en remains equal to in_strobe.
REQ-033 Reset asserted mid-RUN SHALL abort immediately; no out_strobe SHALL follow release.
REQ-034 The first start request after reset SHALL occur at the DECIMATION-th in_strobe.

Structure
REQ-035 FSM state enumeration and the log2 width function SHALL live in the shared receiver package.
REQ-036 The block SHALL be one module with one sub-module, fir_tap_counter: loadable AW-bit down/up address counter pair.
REQ-037 Sample RAM, coefficient ROM and MAC SHALL be external; the I and Q FIRs SHALL share one sequencer.

Verification (TAPS=8, DECIMATION=2, RD_LATENCY=1)
REQ-038 reset, then 2 strobes at cycles 10, 20 -> writes at 0,1; RUN 21..28 with rd_addr 1,0,7,6,5,4,3,2; coeff_addr 0..7; mac_en 22..29; mac_first 22; out_strobe 30.
REQ-039 strobes every 3 cycles, 20 strobes -> wr_addr wraps 7->0; overrun rises at the first dropped start; every accepted start yields exactly one out_strobe.
REQ-040 strobes every 12 cycles -> one out_strobe per 2 strobes; overrun stays 0; busy low between computations.
REQ-041 reset asserted at RUN k=4 -> all outputs at reset values next cycle; no out_strobe; next start at the 2nd strobe after release.
REQ-042 start request in the DONE cycle -> overrun=1; no RUN entry; wr_addr still advances.

Source files
------------

// File: rtl/rx_fir_sequencer_pkg.sv
// Shared receiver package: FIR sequencer state encoding and width helper.
package rx_fir_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fir_state_e;

    // ceil(log2(n)); exact for the power-of-two tap counts used here
    function automatic int fir_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Loadable address counter pair: down counter walks the sample history
// backwards from the newest write, up counter walks coefficients from 0.
module fir_tap_counter #(
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          step_i,
    output logic [AW-1:0] down_o,
    output logic [AW-1:0] up_o
);

    logic [AW-1:0] down_q, down_d;
    logic [AW-1:0] up_q, up_d;

    // next value: load wins over step, otherwise hold
    always_comb begin
        down_d = down_q;
        up_d   = up_q;
        if (load_i) begin
            down_d = load_val_i;
            up_d   = '0;
        end else if (step_i) begin
            down_d = down_q - 1'b1;
            up_d   = up_q + 1'b1;
        end
    end

    // counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            down_q <= '0;
            up_q   <= '0;
        end else begin
            down_q <= down_d;
            up_q   <= up_d;
        end
    end

    assign down_o = down_q;
    assign up_o   = up_q;

endmodule

// File: rtl/rx_fir_sequencer.sv
// Decimating FIR sequencer: writes incoming CIC samples into a circular
// sample RAM and, every DECIMATION strobes, walks TAPS sample/coeff address
// pairs for an external MAC shared by the I and Q paths.
module rx_fir_sequencer
    import rx_fir_sequencer_pkg::*;
#(
    parameter int TAPS       = 256,
    parameter int DECIMATION = 2,
    parameter int RD_LATENCY = 1,
    localparam int AW        = fir_log2(TAPS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_strobe_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [AW-1:0] coeff_addr_o,
    output logic          mac_first_o,
    output logic          mac_en_o,
    output logic          out_strobe_o,
    output logic          busy_o,
    output logic          overrun_o
);

    localparam logic [3:0]    PH_LAST  = 4'(DECIMATION - 1);
    localparam logic [1:0]    DR_LAST  = 2'(RD_LATENCY - 1);
    localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);

    fir_state_e state_q, state_d;
    logic [AW-1:0] wr_addr_q;
    logic [3:0]    phase_q, phase_d;
    logic [1:0]    drain_q, drain_d;
    logic          overrun_q;
    logic          start_req;
    logic          load, step;
    logic          run_first;
    logic [RD_LATENCY-1:0] en_pipe_q, first_pipe_q;

    assign start_req = in_strobe_i && (phase_q == PH_LAST);
    assign phase_d   = (phase_q == PH_LAST) ? 4'd0 : phase_q + 4'd1;
    assign run_first = (state_q == ST_RUN) && (coeff_addr_o == '0);

    // next-state logic; addresses only move while in RUN
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (coeff_addr_o == TAP_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DR_LAST) state_d = ST_DONE;
                else                    drain_d = drain_q + 2'd1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // state, write pointer, phase and sticky overrun
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            phase_q   <= '0;
            drain_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (in_strobe_i) begin
                wr_addr_q <= wr_addr_q + 1'b1;
                phase_q   <= phase_d;
            end
            // any start seen outside IDLE (including DONE) is dropped
            if (start_req && (state_q != ST_IDLE)) overrun_q <= 1'b1;
        end
    end

    // delay MAC controls by the memory read latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_pipe_q    <= '0;
            first_pipe_q <= '0;
        end else begin
            en_pipe_q[0]    <= (state_q == ST_RUN);
            first_pipe_q[0] <= run_first;
            for (int i = 1; i < RD_LATENCY; i++) begin
                en_pipe_q[i]    <= en_pipe_q[i-1];
                first_pipe_q[i] <= first_pipe_q[i-1];
            end
        end
    end

    fir_tap_counter #(.AW(AW)) u_tap_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .load_val_i (wr_addr_q),
        .step_i     (step),
        .down_o     (rd_addr_o),
        .up_o       (coeff_addr_o)
    );

    assign wr_en_o      = in_strobe_i;
    assign wr_addr_o    = wr_addr_q;
    assign mac_en_o     = en_pipe_q[RD_LATENCY-1];
    assign mac_first_o  = first_pipe_q[RD_LATENCY-1];
    assign out_strobe_o = (state_q == ST_DONE);
    assign busy_o       = (state_q != ST_IDLE);
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_rx_fir_sequencer.sv
// Directed bench for rx_fir_sequencer with TAPS=8, DECIMATION=2, RD_LATENCY=1.
module tb_rx_fir_sequencer;

    localparam int TAPS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_strobe = 1'b0;
    logic       wr_en, mac_first, mac_en, out_strobe, busy, overrun;
    logic [2:0] wr_addr, rd_addr, coeff_addr;

    int         checks = 0;
    int         passed = 0;
    int         fails  = 0;
    int         out_cnt = 0;
    logic [2:0] exp_wr = '0;

    always #5 clk = ~clk;

    rx_fir_sequencer #(.TAPS(TAPS), .DECIMATION(2), .RD_LATENCY(1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_strobe_i  (in_strobe),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .rd_addr_o    (rd_addr),
        .coeff_addr_o (coeff_addr),
        .mac_first_o  (mac_first),
        .mac_en_o     (mac_en),
        .out_strobe_o (out_strobe),
        .busy_o       (busy),
        .overrun_o    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock, tallying out_strobe of the cycle being left
    task automatic step();
        if (out_strobe === 1'b1) out_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // one-cycle input strobe; checks the write side of that cycle
    task automatic strobe();
        in_strobe = 1'b1;
        #1;
        chk("wr_en_follows", wr_en, 1'b1);
        chk("wr_addr", wr_addr, exp_wr);
        step();
        in_strobe = 1'b0;
        exp_wr = exp_wr + 3'd1;
    endtask

    initial begin
        // reset state
        idle(3);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_coeff", coeff_addr, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(5);

        // basic convolution: first strobe only advances phase
        strobe();
        chk("no_start_1st", busy, 0);
        idle(8);
        chk("idle_busy", busy, 0);
        strobe();                       // A=1, start
        for (int k = 0; k < TAPS; k++) begin
            chk("run_busy", busy, 1);
            chk("run_rd_addr", rd_addr, 32'((1 - k) & 7));
            chk("run_coeff", coeff_addr, k);
            chk("run_mac_en", mac_en, (k >= 1));
            chk("run_mac_first", mac_first, (k == 1));
            chk("run_out", out_strobe, 0);
            step();
        end
        chk("drain_mac_en", mac_en, 1);
        chk("drain_first", mac_first, 0);
        chk("drain_out", out_strobe, 0);
        step();
        chk("done_out", out_strobe, 1);
        chk("done_busy", busy, 1);
        chk("done_mac_en", mac_en, 0);
        step();
        chk("after_busy", busy, 0);
        chk("after_out", out_strobe, 0);
        chk("hold_rd", rd_addr, 2);
        chk("hold_coeff", coeff_addr, 7);

        // start request landing in the DONE cycle
        strobe();                       // wr 2, phase -> 1
        idle(2);
        strobe();                       // wr 3, start at T; now T+1
        chk("t2_busy", busy, 1);
        idle(2);                        // T+3
        strobe();                       // wr 4 during RUN; now T+4
        idle(6);                        // T+10 = DONE
        chk("t2_done", out_strobe, 1);
        strobe();                       // wr 5 in DONE -> dropped
        chk("t2_overrun", overrun, 1);
        chk("t2_no_run", busy, 0);
        chk("t2_wr_adv", wr_addr, 6);
        idle(3);
        chk("t2_still_idle", busy, 0);

        // reset in the middle of RUN
        strobe();                       // wr 6
        idle(1);
        strobe();                       // wr 7, start; RUN k=0
        idle(4);
        chk("t3_k4_rd", rd_addr, 3);
        chk("t3_k4_coeff", coeff_addr, 4);
        rst = 1'b1;
        #1;
        chk("t3_busy", busy, 0);
        chk("t3_mac_en", mac_en, 0);
        chk("t3_rd", rd_addr, 0);
        chk("t3_coeff", coeff_addr, 0);
        chk("t3_wr", wr_addr, 0);
        chk("t3_overrun", overrun, 0);
        in_strobe = 1'b1;
        #1;
        chk("t3_wr_en_in_rst", wr_en, 1);
        in_strobe = 1'b0;
        idle(2);
        rst = 1'b0;
        exp_wr = '0;
        out_cnt = 0;
        idle(15);
        chk("t3_no_out", out_cnt, 0);
        strobe();
        chk("t3_first_no_start", busy, 0);
        strobe();
        chk("t3_second_start", busy, 1);
        chk("t3_second_rd", rd_addr, 1);
        idle(12);
        chk("t3_end_idle", busy, 0);

        // strobes every 3 cycles: wrap and overrun
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_wr = '0;
        out_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            strobe();
            if (i == 2) chk("t4_ovr_before", overrun, 0);
            if (i == 3) chk("t4_ovr_rise", overrun, 1);
            idle(2);
        end
        idle(15);
        chk("t4_out_cnt", out_cnt, 5);
        chk("t4_wr_wrapped", wr_addr, 32'(20 % 8));

        // strobes every 12 cycles: no overrun, idle between jobs
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_wr = '0;
        out_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            chk("t5_idle_gap", busy, 0);
            strobe();
            idle(11);
        end
        idle(12);
        chk("t5_out_cnt", out_cnt, 4);
        chk("t5_overrun", overrun, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
